// File: rtl/switch_output_buffer.sv
// Output-side packet buffer: four independent port FIFOs drained by a single read port,
// with per-port accept counters, a saturating drop counter and a run timer.
module switch_output_buffer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reset_rams,
    input  logic          write_enable,
    input  logic          out_ram_wr0,
    input  logic          out_ram_wr1,
    input  logic          out_ram_wr2,
    input  logic          out_ram_wr3,
    input  logic [DW-1:0] output0,
    input  logic [DW-1:0] output1,
    input  logic [DW-1:0] output2,
    input  logic [DW-1:0] output3,
    input  logic          rd_req,
    input  logic [1:0]    rd_port,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [3:0]    empty,
    output logic [3:0]    full,
    output logic [7:0]    hex1,
    output logic [7:0]    hex2,
    output logic [7:0]    hex3,
    output logic [7:0]    hex4,
    output logic [7:0]    hex5,
    output logic [7:0]    hex6,
    output logic [31:0]   total_time
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [3:0]    w_wr;
    logic [DW-1:0] w_din [4];

    assign w_wr     = {out_ram_wr3, out_ram_wr2, out_ram_wr1, out_ram_wr0};
    assign w_din[0] = output0;
    assign w_din[1] = output1;
    assign w_din[2] = output2;
    assign w_din[3] = output3;

    logic [DW-1:0] r_mem     [4][DEPTH];
    logic [AW-1:0] r_wptr    [4];
    logic [AW-1:0] r_rptr    [4];
    logic [AW:0]   r_count   [4];
    logic [7:0]    r_acc_cnt [4];
    logic [3:0]    r_empty;
    logic [3:0]    r_full;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic [7:0]    r_hex5;
    logic [7:0]    r_hex6;
    logic [31:0]   r_time;

    logic          w_pop;
    logic [3:0]    w_pop_n;
    logic [3:0]    w_acc;
    logic [3:0]    w_drop;
    logic [AW:0]   w_count_d [4];
    logic [2:0]    w_ndrop;
    logic [8:0]    w_hex5_sum;
    logic [7:0]    w_hex6_d;

    assign w_pop   = rd_req && (r_count[rd_port] != '0);
    assign w_pop_n = w_pop ? (4'b0001 << rd_port) : 4'b0000;

    // A pop on a full FIFO frees the slot the same-cycle write lands in.
    always_comb begin
        w_acc    = '0;
        w_drop   = '0;
        w_ndrop  = '0;
        w_hex6_d = r_hex6;
        for (int i = 3; i >= 0; i--) begin
            w_acc[i]     = w_wr[i] && ((r_count[i] != CNT_FULL) || w_pop_n[i]);
            w_drop[i]    = w_wr[i] && !w_acc[i];
            w_count_d[i] = r_count[i] + {{AW{1'b0}}, w_acc[i]} - {{AW{1'b0}}, w_pop_n[i]};
            w_ndrop      = w_ndrop + {2'b00, w_drop[i]};
            if (w_acc[i]) begin
                w_hex6_d = w_din[i][7:0];
            end
        end
        w_hex5_sum = {1'b0, r_hex5} + {6'b000000, w_ndrop};
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_acc[i] && !reset_rams) begin
                r_mem[i][r_wptr[i]] <= w_din[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_wptr[i]    <= '0;
                r_rptr[i]    <= '0;
                r_count[i]   <= '0;
                r_acc_cnt[i] <= '0;
            end
            r_empty    <= 4'hF;
            r_full     <= 4'h0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_hex5     <= '0;
            r_hex6     <= '0;
            r_time     <= '0;
        end else if (reset_rams) begin
            for (int i = 0; i < 4; i++) begin
                r_wptr[i]    <= '0;
                r_rptr[i]    <= '0;
                r_count[i]   <= '0;
                r_acc_cnt[i] <= '0;
            end
            r_empty    <= 4'hF;
            r_full     <= 4'h0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_hex5     <= '0;
            r_hex6     <= '0;
            r_time     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc[i]) begin
                    r_wptr[i]    <= r_wptr[i] + 1'b1;
                    r_acc_cnt[i] <= r_acc_cnt[i] + 8'd1;
                end
                if (w_pop_n[i]) begin
                    r_rptr[i] <= r_rptr[i] + 1'b1;
                end
                r_count[i] <= w_count_d[i];
                r_empty[i] <= (w_count_d[i] == '0);
                r_full[i]  <= (w_count_d[i] == CNT_FULL);
            end
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[rd_port][r_rptr[rd_port]];
            end
            r_hex5 <= w_hex5_sum[8] ? 8'hFF : w_hex5_sum[7:0];
            r_hex6 <= w_hex6_d;
            if (write_enable) begin
                r_time <= r_time + 32'd1;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign empty      = r_empty;
    assign full       = r_full;
    assign hex1       = r_acc_cnt[0];
    assign hex2       = r_acc_cnt[1];
    assign hex3       = r_acc_cnt[2];
    assign hex4       = r_acc_cnt[3];
    assign hex5       = r_hex5;
    assign hex6       = r_hex6;
    assign total_time = r_time;

endmodule

// File: tb/tb_switch_output_buffer.sv
// Bench for switch_output_buffer: queue-based reference model, popped words go through a
// scoreboard checked by an independent monitor.
module tb_switch_output_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tb_rr = 1'b0;
    logic          tb_we = 1'b0;
    logic [3:0]    tb_wr = '0;
    logic [DW-1:0] tb_din [4];
    logic          tb_rd_req = 1'b0;
    logic [1:0]    tb_rd_port = '0;

    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [3:0]    empty;
    logic [3:0]    full;
    logic [7:0]    hex1, hex2, hex3, hex4, hex5, hex6;
    logic [31:0]   total_time;

    switch_output_buffer #(
        .DW   (DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reset_rams  (tb_rr),
        .write_enable(tb_we),
        .out_ram_wr0 (tb_wr[0]),
        .out_ram_wr1 (tb_wr[1]),
        .out_ram_wr2 (tb_wr[2]),
        .out_ram_wr3 (tb_wr[3]),
        .output0     (tb_din[0]),
        .output1     (tb_din[1]),
        .output2     (tb_din[2]),
        .output3     (tb_din[3]),
        .rd_req      (tb_rd_req),
        .rd_port     (tb_rd_port),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex4        (hex4),
        .hex5        (hex5),
        .hex6        (hex6),
        .total_time  (total_time)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mq [4][$];
    logic [7:0]    m_acc [4];
    int            m_drop;
    logic [7:0]    m_hex6;
    logic [31:0]   m_time;
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_acc[i] = '0;
        end
        m_drop     = 0;
        m_hex6     = '0;
        m_time     = '0;
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        exp_q.delete();
    endfunction

    // Read is resolved before the writes so a pop on a full FIFO makes room, and a pop on an
    // empty FIFO cannot see the word written in the same cycle.
    function automatic void model_step();
        bit hex6_set;
        if (tb_rr) begin
            model_clear();
            return;
        end
        m_rd_valid = 1'b0;
        if (tb_rd_req && mq[tb_rd_port].size() > 0) begin
            m_rd_data  = mq[tb_rd_port].pop_front();
            m_rd_valid = 1'b1;
            exp_q.push_back(m_rd_data);
        end
        hex6_set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (tb_wr[i]) begin
                if (mq[i].size() < DEPTH) begin
                    mq[i].push_back(tb_din[i]);
                    m_acc[i] = m_acc[i] + 8'd1;
                    if (!hex6_set) begin
                        m_hex6   = tb_din[i][7:0];
                        hex6_set = 1'b1;
                    end
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
        if (tb_we) m_time = m_time + 32'd1;
    endfunction

    task automatic check_all();
        logic [3:0] e;
        logic [3:0] f;
        for (int i = 0; i < 4; i++) begin
            e[i] = (mq[i].size() == 0);
            f[i] = (mq[i].size() == DEPTH);
        end
        chk("empty", 64'(empty), 64'(e));
        chk("full", 64'(full), 64'(f));
        chk("hex1", 64'(hex1), 64'(m_acc[0]));
        chk("hex2", 64'(hex2), 64'(m_acc[1]));
        chk("hex3", 64'(hex3), 64'(m_acc[2]));
        chk("hex4", 64'(hex4), 64'(m_acc[3]));
        chk("hex5", 64'(hex5), 64'(m_drop));
        chk("hex6", 64'(hex6), 64'(m_hex6));
        chk("total_time", 64'(total_time), 64'(m_time));
        chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        chk("rd_data", 64'(rd_data), 64'(m_rd_data));
    endtask

    task automatic step(input logic [3:0] wr, input logic rq, input logic [1:0] rp,
                        input logic we, input logic rr);
        tb_wr      = wr;
        tb_rd_req  = rq;
        tb_rd_port = rp;
        tb_we      = we;
        tb_rr      = rr;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // Called just after a posedge; reset drops between edges to exercise the async path.
    task automatic async_reset();
        tb_wr     = '0;
        tb_rd_req = 1'b0;
        tb_we     = 1'b0;
        tb_rr     = 1'b0;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("arst_empty", 64'(empty), 64'(4'hF));
        chk("arst_full", 64'(full), 64'(4'h0));
        chk("arst_rd_valid", 64'(rd_valid), 64'(0));
        chk("arst_hex5", 64'(hex5), 64'(0));
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all();
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the next expected popped word.
    always @(negedge clk) begin
        if (reset && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_pop: rd_valid=1 rd_data=%0h with no pop expected", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_rd_data", 64'(rd_data), 64'(mon_exp));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) tb_din[i] = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Single word through port 2
        tb_din[2] = 32'hA1B2C3D4;
        step(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
        chk("t2_rd_data", 64'(rd_data), 64'(32'hA1B2C3D4));
        chk("t2_rd_valid", 64'(rd_valid), 64'(1));
        chk("t2_hex3", 64'(hex3), 64'(1));
        chk("t2_hex6", 64'(hex6), 64'(8'hD4));
        idle();
        chk("t2_empty2", 64'(empty[2]), 64'(1));
        chk("t2_rd_hold", 64'(rd_data), 64'(32'hA1B2C3D4));

        // Overfill port 0, drain in order, then read past empty
        async_reset();
        for (int k = 0; k < 17; k++) begin
            tb_din[0] = 32'(k);
            step(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        chk("t3_full0", 64'(full[0]), 64'(1));
        chk("t3_hex1", 64'(hex1), 64'(16));
        chk("t3_hex5", 64'(hex5), 64'(1));
        for (int k = 0; k < 16; k++) step(4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("t3_last", 64'(rd_data), 64'(15));
        step(4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("t3_empty_read", 64'(rd_valid), 64'(0));

        // Write and read together on a full FIFO
        async_reset();
        for (int k = 0; k < 16; k++) begin
            tb_din[1] = 32'(100 + k);
            step(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        tb_din[1] = 32'h55;
        step(4'b0010, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("t4_old_head", 64'(rd_data), 64'(100));
        chk("t4_still_full", 64'(full[1]), 64'(1));
        chk("t4_hex5", 64'(hex5), 64'(0));
        for (int k = 0; k < 16; k++) step(4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("t4_tail", 64'(rd_data), 64'(32'h55));

        // Write and read together on an empty FIFO
        tb_din[1] = 32'h66;
        step(4'b0010, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("t4b_no_pop", 64'(rd_valid), 64'(0));

        // All four ports at once
        async_reset();
        for (int i = 0; i < 4; i++) tb_din[i] = 32'(16 + i);
        step(4'b1111, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t5_hex6", 64'(hex6), 64'(8'h10));
        chk("t5_hex4", 64'(hex4), 64'(1));

        // Run timer, then synchronous clear alongside a write
        async_reset();
        repeat (100) step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        repeat (10) step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t6_time", 64'(total_time), 64'(100));
        tb_din[3] = 32'h77;
        step(4'b1000, 1'b0, 2'd0, 1'b1, 1'b1);
        chk("t6_empty", 64'(empty), 64'(4'hF));
        chk("t6_hex4", 64'(hex4), 64'(0));
        chk("t6_time0", 64'(total_time), 64'(0));

        // Random traffic: write-heavy then read-heavy, occasional synchronous clear
        for (int n = 0; n < 1400; n++) begin
            logic [3:0] wr;
            logic       rq;
            for (int i = 0; i < 4; i++) tb_din[i] = $urandom;
            if (n < 700) begin
                wr = 4'($urandom_range(0, 15));
                rq = ($urandom_range(0, 3) == 0);
            end else begin
                for (int i = 0; i < 4; i++) wr[i] = ($urandom_range(0, 3) == 0);
                rq = ($urandom_range(0, 3) != 0);
            end
            step(wr, rq, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 299) == 0));
        end

        // Mid-operation asynchronous reset with data queued
        for (int i = 0; i < 4; i++) tb_din[i] = $urandom;
        step(4'b1111, 1'b1, 2'd3, 1'b1, 1'b0);
        async_reset();
        idle();
        idle();
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
